// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: move direction codes (common to the frog
// movement path and the VGA controller) and the move-encoder FSM states.
package frogger_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    // Number of press events in one cycle (0..4).
    function automatic logic [2:0] count_ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/switch_move_encoder_if.sv
// Move command handshake: the encoder (master) offers move_dir with
// move_valid, the frog movement controller (slave) accepts with move_ready.
interface switch_move_encoder_if;

    logic       move_valid;
    logic       move_ready;
    logic [1:0] move_dir;

    modport master (output move_valid, output move_dir, input move_ready);
    modport slave  (input move_valid, input move_dir, output move_ready);

endinterface

// File: rtl/switch_move_encoder_debouncer.sv
// One raw switch: two-flop synchroniser, stability counter, debounced level
// and a registered one-cycle pulse on each accepted 0->1 transition.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then accept a new level only after it has held long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            rise     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sync1->sync2 a real two-stage
            // shift; blocking ones would collapse the synchroniser to one flop.
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            rise     <= stable & ~stable_d;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_move_encoder.sv
// Turns four raw board switches into one-at-a-time move commands over a
// valid/ready handshake. Optional auto-repeat of a held switch is enabled
// by defining SWITCH_AUTO_REPEAT_EN.
module switch_move_encoder
    import frogger_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 250000,
    parameter int REPEAT_DELAY_CYCLES  = 12500000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         switch1,
    input  logic                         switch2,
    input  logic                         switch3,
    input  logic                         switch4,
    switch_move_encoder_if.master        move,
    output logic [3:0]                   sw_stable,
    output logic [7:0]                   drop_count
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_cfg
        $error("switch_move_encoder: DEBOUNCE_CYCLES >= 2 and repeat intervals >= 1 required");
    end

    logic [3:0] sw_raw;
    logic [3:0] press;
    logic [1:0] state;
    logic [1:0] winner;
    logic [2:0] n_press;
    logic [2:0] drop_inc;
    logic [8:0] drop_sum;
    logic [7:0] drop_next;

    assign sw_raw = {switch4, switch3, switch2, switch1};

    for (genvar i = 0; i < 4; i++) begin : g_sw
        switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i]),
            .rise   (press[i])
        );
    end

    // Fixed-priority winner and the number of presses discarded this cycle.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves one
        // unassigned, which would otherwise infer a latch.
        winner   = DIR_UP;
        drop_inc = 3'd0;
        if (press[0])      winner = DIR_UP;
        else if (press[1]) winner = DIR_DOWN;
        else if (press[2]) winner = DIR_LEFT;
        else if (press[3]) winner = DIR_RIGHT;
        n_press = count_ones4(press);
        if (state == ST_PENDING)  drop_inc = n_press;
        else if (n_press != 3'd0) drop_inc = n_press - 3'd1;
        drop_sum  = {1'b0, drop_count} + {6'b0, drop_inc};
        drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Saturating count of discarded press events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_count <= 8'd0;
        else       drop_count <= drop_next;
    end

`ifdef SWITCH_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RPT_W = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_last;

    assign rpt_last = rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
`endif

    // Move FSM: accept a press, hold it until transferred, then track the hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            move.move_valid <= 1'b0;
            move.move_dir   <= DIR_UP;
`ifdef SWITCH_AUTO_REPEAT_EN
            rpt_cnt         <= '0;
            rpt_first       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|press) begin
                        move.move_dir   <= winner;
                        move.move_valid <= 1'b1;
                        state           <= ST_PENDING;
`ifdef SWITCH_AUTO_REPEAT_EN
                        rpt_first       <= 1'b1;
`endif
                    end
                end
                ST_PENDING: begin
                    if (move.move_ready) begin
                        move.move_valid <= 1'b0;
                        state           <= sw_stable[move.move_dir] ? ST_HELD : ST_IDLE;
`ifdef SWITCH_AUTO_REPEAT_EN
                        rpt_cnt         <= '0;
`endif
                    end
                end
                ST_HELD: begin
                    if (|press) begin
                        move.move_dir   <= winner;
                        move.move_valid <= 1'b1;
                        state           <= ST_PENDING;
`ifdef SWITCH_AUTO_REPEAT_EN
                        rpt_first       <= 1'b1;
`endif
                    end else if (!sw_stable[move.move_dir]) begin
                        state <= ST_IDLE;
`ifdef SWITCH_AUTO_REPEAT_EN
                    end else if (rpt_cnt == rpt_last) begin
                        move.move_valid <= 1'b1;
                        state           <= ST_PENDING;
                        rpt_first       <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
